// File: rtl/pkt_out_scheduler.sv
// Output scheduler: round-robin over ports, strict priority within a port, then one chain-manager
// request and an SRAM read burst per packet. Optional macro RESP_TIMEOUT_EN adds a WAIT timeout.
module pkt_out_scheduler #(
  parameter int unsigned PORTS  = 16,
  parameter int unsigned PRIOS  = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned SIZE_W = 8,
  parameter int unsigned TMO    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS*PRIOS-1:0]     q_nonempty,
  input  logic [PORTS-1:0]           port_ready,
  output logic                       rea,
  output logic [PORTS*PRIOS-1:0]     out_port,
  input  logic                       read_allowed,
  input  logic [ADDR_W-1:0]          start_read_address,
  input  logic [SIZE_W-1:0]          r_size,
  output logic                       sram_ren,
  output logic [ADDR_W-1:0]          sram_raddr,
  output logic                       tx_valid,
  output logic                       tx_sop,
  output logic                       tx_eop,
  output logic [$clog2(PORTS)-1:0]   tx_port,
  output logic                       busy,
  output logic                       resp_err
);

  localparam int unsigned PW = $clog2(PORTS);
  localparam int unsigned RW = $clog2(PRIOS);
  localparam int unsigned NQ = PORTS * PRIOS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] XFER = 2'd3;

  // Queue index is the concatenation {port, prio}, so both counts must be powers of two.
  if ((PORTS & (PORTS - 1)) != 0 || (PRIOS & (PRIOS - 1)) != 0 || TMO == 0) begin : g_param_err
    $error("pkt_out_scheduler: PORTS/PRIOS must be powers of two and TMO nonzero");
  end

  logic [1:0]        state_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [PW-1:0]     port_q;
  logic [SIZE_W-1:0] len_q;
  logic [SIZE_W-1:0] cnt_q;

  logic              pick_found;
  logic [PW-1:0]     pick_port;
  logic [RW-1:0]     pick_prio;
  logic [PW-1:0]     cand;

  always_comb begin
    pick_found = 1'b0;
    pick_port  = '0;
    pick_prio  = '0;
    cand       = '0;
    // Scan from the far end so the port closest to rr_ptr is the last (winning) assignment.
    for (int i = PORTS - 1; i >= 0; i--) begin
      cand = rr_ptr_q + PW'(i);
      if (port_ready[cand] && |q_nonempty[{cand, RW'(0)} +: PRIOS]) begin
        pick_found = 1'b1;
        pick_port  = cand;
      end
    end
    for (int j = 0; j < PRIOS; j++) begin
      if (q_nonempty[{pick_port, RW'(j)}]) pick_prio = RW'(j);
    end
  end

  assign busy = (state_q != IDLE);

`ifdef RESP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q;
  logic          resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      port_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rea        <= 1'b0;
      out_port   <= '0;
      sram_ren   <= 1'b0;
      sram_raddr <= '0;
      tx_valid   <= 1'b0;
      tx_sop     <= 1'b0;
      tx_eop     <= 1'b0;
      tx_port    <= '0;
`ifdef RESP_TIMEOUT_EN
      tmo_q      <= '0;
      resp_err_q <= 1'b0;
`endif
    end else begin
      rea      <= 1'b0;
      out_port <= '0;
      tx_valid <= sram_ren;
      tx_sop   <= (state_q == XFER) && (cnt_q == '0);
      tx_eop   <= (state_q == XFER) && (cnt_q == len_q - SIZE_W'(1));
`ifdef RESP_TIMEOUT_EN
      resp_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            port_q   <= pick_port;
            rea      <= 1'b1;
            out_port <= NQ'(1) << {pick_port, pick_prio};
            state_q  <= REQ;
          end
        end
        REQ: begin
          state_q <= WAIT;
`ifdef RESP_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        WAIT: begin
          if (read_allowed) begin
            rr_ptr_q <= port_q + PW'(1);
            len_q    <= r_size;
            cnt_q    <= '0;
            if (r_size == '0) begin
              state_q <= IDLE;
            end else begin
              state_q    <= XFER;
              sram_ren   <= 1'b1;
              sram_raddr <= start_read_address;
              tx_port    <= port_q;
            end
`ifdef RESP_TIMEOUT_EN
          end else if (tmo_q == TW'(TMO - 1)) begin
            resp_err_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
`endif
          end
        end
        XFER: begin
          if (cnt_q == len_q - SIZE_W'(1)) begin
            sram_ren <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q      <= cnt_q + SIZE_W'(1);
            sram_raddr <= sram_raddr + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_out_scheduler.sv
// Scoreboard bench for pkt_out_scheduler: stimulus pushes expected requests/words, a monitor pops.
`timescale 1ns/1ps
module tb_pkt_out_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] q_nonempty = '0;
  logic [15:0]  port_ready = '0;
  logic         rea;
  logic [127:0] out_port;
  logic         read_allowed = 1'b0;
  logic [11:0]  start_read_address = '0;
  logic [7:0]   r_size = '0;
  logic         sram_ren;
  logic [11:0]  sram_raddr;
  logic         tx_valid, tx_sop, tx_eop;
  logic [3:0]   tx_port;
  logic         busy, resp_err;

  int tests = 0;
  int fails = 0;

  int          exp_req[$];
  logic [11:0] exp_addr[$];
  logic [5:0]  exp_tx[$];

  pkt_out_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .q_nonempty         (q_nonempty),
    .port_ready         (port_ready),
    .rea                (rea),
    .out_port           (out_port),
    .read_allowed       (read_allowed),
    .start_read_address (start_read_address),
    .r_size             (r_size),
    .sram_ren           (sram_ren),
    .sram_raddr         (sram_raddr),
    .tx_valid           (tx_valid),
    .tx_sop             (tx_sop),
    .tx_eop             (tx_eop),
    .tx_port            (tx_port),
    .busy               (busy),
    .resp_err           (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output against the head of its queue.
  always begin
    logic [127:0] oh;
    step();
    if (rea) begin
      if (exp_req.size() == 0) check("unexpected rea", out_port, 128'd0);
      else begin
        oh = '0;
        oh[exp_req.pop_front()] = 1'b1;
        check("out_port", out_port, oh);
      end
    end
    if (sram_ren) begin
      if (exp_addr.size() == 0) check("unexpected sram_ren", {116'd0, sram_raddr}, 128'hdead);
      else check("sram_raddr", {116'd0, sram_raddr}, {116'd0, exp_addr.pop_front()});
    end
    if (tx_valid) begin
      if (exp_tx.size() == 0) check("unexpected tx_valid", {122'd0, tx_sop, tx_eop, tx_port}, 128'hdead);
      else check("tx sop/eop/port", {122'd0, tx_sop, tx_eop, tx_port}, {122'd0, exp_tx.pop_front()});
    end
`ifndef RESP_TIMEOUT_EN
    if (resp_err) check("resp_err tied low", {127'd0, resp_err}, 128'd0);
`endif
  end

  task automatic push_burst(input logic [11:0] base, input int len, input logic [3:0] port);
    for (int k = 0; k < len; k++) begin
      exp_addr.push_back(base + 12'(k));
      exp_tx.push_back({k == 0, k == len - 1, port});
    end
  endtask

  task automatic wait_rea(output int lat, output bit ok);
    lat = 0;
    while (!rea && lat < 20) begin
      step();
      lat++;
    end
    ok = rea;
    if (!ok) check("rea timeout", 128'd0, 128'd1);
  endtask

  // Waits for rea, then answers during the WAIT cycle; returns one cycle after that.
  task automatic request_respond(input int idx, input logic [11:0] base, input logic [7:0] len,
                                 output int lat);
    bit ok;
    exp_req.push_back(idx);
    wait_rea(lat, ok);
    if (!ok) return;
    step();
    read_allowed = 1'b1;
    start_read_address = base;
    r_size = len;
    step();
    read_allowed = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 600) begin
      step();
      n++;
    end
    if (busy) check("busy timeout", 128'd1, 128'd0);
  endtask

  task automatic serve(input int idx, input logic [11:0] base, input logic [7:0] len,
                       input logic [3:0] port);
    int lat;
    push_burst(base, int'(len), port);
    request_respond(idx, base, len, lat);
    wait_idle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ctrl bits"}, {121'd0, rea, sram_ren, tx_valid, tx_sop, tx_eop, busy, resp_err}, 0);
    check({tag, " out_port"}, out_port, 0);
    check({tag, " sram_raddr"}, {116'd0, sram_raddr}, 0);
    check({tag, " tx_port"}, {124'd0, tx_port}, 0);
    check({tag, " rr_ptr"}, {124'd0, dut.rr_ptr_q}, 0);
  endtask

  initial begin
    int lat;
    bit ok;
    repeat (3) step();
    rst = 1'b0;
    check_reset_state("reset");
    step();

    // Single queue, port 3 prio 5.
    q_nonempty[29] = 1'b1;
    port_ready[3] = 1'b1;
    push_burst(12'h100, 4, 4'd3);
    request_respond(29, 12'h100, 8'd4, lat);
    check("rea latency", lat, 1);
    wait_idle();
    q_nonempty = '0;
    port_ready = '0;

    // Strict priority inside port 4.
    q_nonempty[33] = 1'b1;
    q_nonempty[38] = 1'b1;
    port_ready[4] = 1'b1;
    serve(38, 12'h040, 8'd2, 4'd4);
    q_nonempty = '0;
    port_ready = '0;

    // Address wrap.
    q_nonempty[8] = 1'b1;
    port_ready[1] = 1'b1;
    serve(8, 12'hFFE, 8'd4, 4'd1);
    q_nonempty = '0;
    port_ready = '0;

    // Zero-length packet: no burst, idle two cycles after rea.
    q_nonempty[43] = 1'b1;
    port_ready[5] = 1'b1;
    request_respond(43, 12'h123, 8'd0, lat);
    check("len0 busy", {127'd0, busy}, 0);
    q_nonempty = '0;
    port_ready = '0;
    repeat (3) step();

    // Single-word packet: sop and eop together.
    q_nonempty[55] = 1'b1;
    port_ready[6] = 1'b1;
    serve(55, 12'h3A0, 8'd1, 4'd6);
    q_nonempty = '0;
    port_ready = '0;

    // Round robin between ports 2 and 9 from rr_ptr=0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_nonempty[16] = 1'b1;
    q_nonempty[72] = 1'b1;
    port_ready[2] = 1'b1;
    port_ready[9] = 1'b1;
    serve(16, 12'h010, 8'd2, 4'd2);
    check("rr_ptr after port 2", {124'd0, dut.rr_ptr_q}, 3);
    serve(72, 12'h020, 8'd3, 4'd9);
    serve(16, 12'h030, 8'd1, 4'd2);
    q_nonempty = '0;
    port_ready = '0;
    repeat (2) step();

`ifdef RESP_TIMEOUT_EN
    // No response: resp_err 15 cycles after WAIT entry, same queue requested again.
    q_nonempty[80] = 1'b1;
    port_ready[10] = 1'b1;
    exp_req.push_back(80);
    wait_rea(lat, ok);
    lat = 0;
    while (!resp_err && lat < 40) begin
      step();
      lat++;
    end
    check("resp_err delay from rea", lat, 16);
    check("rr_ptr after timeout", {124'd0, dut.rr_ptr_q}, 3);
    step();
    check("resp_err pulse width", {127'd0, resp_err}, 0);
    serve(80, 12'h555, 8'd1, 4'd10);
    q_nonempty = '0;
    port_ready = '0;
    repeat (2) step();
`endif

    // Reset in the middle of a burst.
    q_nonempty[58] = 1'b1;
    port_ready[7] = 1'b1;
    push_burst(12'h200, 3, 4'd7);
    exp_tx.pop_back();
    request_respond(58, 12'h200, 8'd8, lat);
    step();
    step();
    rst = 1'b1;
    q_nonempty = '0;
    port_ready = '0;
    step();
    check_reset_state("mid-xfer reset");
    rst = 1'b0;

    repeat (5) step();
    check("req queue drained", exp_req.size(), 0);
    check("addr queue drained", exp_addr.size(), 0);
    check("tx queue drained", exp_tx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
